// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side uses the master modport, the controller uses slave.
interface pipe_hazard_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 16,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_ex_memread;
  logic [REG_AW-1:0] id_ex_rt;
  logic [REG_AW-1:0] if_id_rs;
  logic [REG_AW-1:0] if_id_rt;
  logic              if_id_valid;
  logic [ADDR_W-1:0] pc;
  logic [IMM_W-1:0]  immediate;
  logic              branch_taken;
  logic              mem_busy;
  logic              cnt_clr;

  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              pc_src_sel;
  logic [ADDR_W-1:0] bta;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_ex_memread, id_ex_rt, if_id_rs, if_id_rt, if_id_valid,
           pc, immediate, branch_taken, mem_busy, cnt_clr,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pc_src_sel,
           bta, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ex_memread, id_ex_rt, if_id_rs, if_id_rt, if_id_valid,
           pc, immediate, branch_taken, mem_busy, cnt_clr,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pc_src_sel,
           bta, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / taken-branch / memory-wait hazard controller for a 5-stage pipe,
// with saturating stall and flush performance counters.
module pipe_hazard_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int IMM_W    = 16,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LU_STALL  = 2'd1,
    BR_SQUASH = 2'd2,
    MEM_WAIT  = 2'd3
  } state_e;

  // The detect cycle is the first stall cycle, so LU_STALL covers LOAD_LAT-1 more.
  localparam logic [1:0] CD_INIT = 2'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [1:0]         cd_q, cd_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic [REG_AW-1:0]  exRt, idRs, idRt;
  logic               luHit;
  logic [ADDR_W-1:0]  immExt, branchTarget;
  logic               pcWrite, ifIdWrite, ifIdFlush, idExFlush, pcSrcSel;
  logic [ADDR_W-1:0]  btaOut;
  logic               stallInc, flushInc;

  assign exRt  = hif.id_ex_rt;
  assign idRs  = hif.if_id_rs;
  assign idRt  = hif.if_id_rt;
  assign luHit = hif.id_ex_memread & hif.if_id_valid & (exRt != '0) &
                 ((exRt == idRs) | (exRt == idRt));

  assign immExt       = {{(ADDR_W-IMM_W){hif.immediate[IMM_W-1]}}, hif.immediate};
  assign branchTarget = hif.pc + ADDR_W'(4) + (immExt << 2);

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    pcWrite   = 1'b1;
    ifIdWrite = 1'b1;
    ifIdFlush = 1'b0;
    idExFlush = 1'b0;
    pcSrcSel  = 1'b0;
    btaOut    = '0;
    stallInc  = 1'b0;
    flushInc  = 1'b0;

    if (hif.mem_busy) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      if (state_q == IDLE) state_d = MEM_WAIT;
    end else begin
      case (state_q)
        LU_STALL: begin
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          idExFlush = 1'b1;
          stallInc  = 1'b1;
          if (cd_q == 2'd0) state_d = IDLE;
          else              cd_d    = cd_q - 2'd1;
        end
        BR_SQUASH: begin
          idExFlush = 1'b1;
          state_d   = IDLE;
        end
        // MEM_WAIT releasing falls through to IDLE rules in the same cycle.
        default: begin
          state_d = IDLE;
          if (luHit) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
            stallInc  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LU_STALL;
              cd_d    = CD_INIT;
            end
          end else if (hif.branch_taken) begin
            pcSrcSel  = 1'b1;
            ifIdFlush = 1'b1;
            btaOut    = branchTarget;
            flushInc  = 1'b1;
            if (BR_FLUSH == 2) state_d = BR_SQUASH;
          end
        end
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hif.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stallInc && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flushInc && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cd_q        <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cd_q        <= cd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset freezes the whole pipe, so every control output is forced low.
  assign hif.pc_write    = rst ? 1'b0 : pcWrite;
  assign hif.if_id_write = rst ? 1'b0 : ifIdWrite;
  assign hif.if_id_flush = rst ? 1'b0 : ifIdFlush;
  assign hif.id_ex_flush = rst ? 1'b0 : idExFlush;
  assign hif.pc_src_sel  = rst ? 1'b0 : pcSrcSel;
  assign hif.bta         = rst ? '0   : btaOut;
  assign hif.state       = state_q;
  assign hif.stall_cnt   = stall_cnt_q;
  assign hif.flush_cnt   = flush_cnt_q;

endmodule
